// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: widths, ALU op codes and
// the forwarding-source encoding.
package id_ex_operand_stage_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  // Same 3-bit codes the ALU decodes on ALUCtrl_i.
  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_XOR  = 3'd1,
    ALU_SLL  = 3'd2,
    ALU_ADD  = 3'd3,
    ALU_SUB  = 3'd4,
    ALU_MUL  = 3'd5,
    ALU_ADDI = 3'd6,
    ALU_SRAI = 3'd7
  } alu_op_e;

  // Which bypass path supplied an operand.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-source bypass selector. EX/MEM beats MEM/WB; x0 is never forwarded
// because it always reads as zero from the register file.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int RADDR_W_P = RADDR_W
) (
  input  logic [RADDR_W_P-1:0] src_addr,
  input  logic [XLEN_P-1:0]    reg_data,
  input  logic                 exmem_reg_write,
  input  logic [RADDR_W_P-1:0] exmem_rd,
  input  logic [XLEN_P-1:0]    exmem_data,
  input  logic                 memwb_reg_write,
  input  logic [RADDR_W_P-1:0] memwb_rd,
  input  logic [XLEN_P-1:0]    memwb_data,
  output logic [XLEN_P-1:0]    data,
  output fwd_sel_e             fwd_sel
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_addr);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_addr);

  // Priority select of the freshest producer of this source register.
  always_comb begin
    data    = reg_data;
    fwd_sel = FWD_NONE;
    if (exmem_hit) begin
      data    = exmem_data;
      fwd_sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      data    = memwb_data;
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection. Operand outputs feed the ALU directly.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int RADDR_W_P = RADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [XLEN_P-1:0]    rs1_data_i,
  input  logic [XLEN_P-1:0]    rs2_data_i,
  input  logic [XLEN_P-1:0]    imm_i,
  input  logic [RADDR_W_P-1:0] rs1_addr_i,
  input  logic [RADDR_W_P-1:0] rs2_addr_i,
  input  logic [RADDR_W_P-1:0] rd_addr_i,
  input  logic [2:0]           alu_ctrl_i,
  input  logic                 alu_src_i,
  input  logic                 reg_write_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 mem_to_reg_i,
  input  logic                 exmem_reg_write_i,
  input  logic [RADDR_W_P-1:0] exmem_rd_i,
  input  logic [XLEN_P-1:0]    exmem_data_i,
  input  logic                 memwb_reg_write_i,
  input  logic [RADDR_W_P-1:0] memwb_rd_i,
  input  logic [XLEN_P-1:0]    memwb_data_i,
  output logic [XLEN_P-1:0]    alu_data1_o,
  output logic [XLEN_P-1:0]    alu_data2_o,
  output logic [2:0]           alu_ctrl_o,
  output logic [XLEN_P-1:0]    store_data_o,
  output logic [RADDR_W_P-1:0] rd_addr_o,
  output logic                 reg_write_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 mem_to_reg_o,
  output logic                 valid_o,
  output logic                 load_use_hazard_o
);

  logic                 valid_q;
  logic [XLEN_P-1:0]    rs1_data_q;
  logic [XLEN_P-1:0]    rs2_data_q;
  logic [XLEN_P-1:0]    imm_q;
  logic [RADDR_W_P-1:0] rs1_addr_q;
  logic [RADDR_W_P-1:0] rs2_addr_q;
  logic [RADDR_W_P-1:0] rd_addr_q;
  logic [2:0]           alu_ctrl_q;
  logic                 alu_src_q;
  logic                 reg_write_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic                 mem_to_reg_q;

  logic [XLEN_P-1:0]    rs1_fwd;
  logic [XLEN_P-1:0]    rs2_fwd;
  fwd_sel_e             rs1_sel;
  fwd_sel_e             rs2_sel;
  logic                 unused_fwd_sel;

  // Stage register: flush inserts a zeroed bubble, stall holds, else load.
  // Side-effecting control is gated by valid_i at capture so a bubble from
  // ID can never write a register or touch memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      alu_ctrl_q   <= ALU_AND;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      alu_ctrl_q   <= ALU_AND;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q      <= valid_i;
      rs1_data_q   <= rs1_data_i;
      rs2_data_q   <= rs2_data_i;
      imm_q        <= imm_i;
      rs1_addr_q   <= rs1_addr_i;
      rs2_addr_q   <= rs2_addr_i;
      rd_addr_q    <= rd_addr_i;
      alu_ctrl_q   <= alu_ctrl_i;
      alu_src_q    <= alu_src_i;
      reg_write_q  <= valid_i & reg_write_i;
      mem_read_q   <= valid_i & mem_read_i;
      mem_write_q  <= valid_i & mem_write_i;
      mem_to_reg_q <= mem_to_reg_i;
    end
  end

  id_ex_operand_stage_fwd_mux #(
    .XLEN_P    (XLEN_P),
    .RADDR_W_P (RADDR_W_P)
  ) u_fwd_rs1 (
    .src_addr        (rs1_addr_q),
    .reg_data        (rs1_data_q),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_data      (memwb_data_i),
    .data            (rs1_fwd),
    .fwd_sel         (rs1_sel)
  );

  id_ex_operand_stage_fwd_mux #(
    .XLEN_P    (XLEN_P),
    .RADDR_W_P (RADDR_W_P)
  ) u_fwd_rs2 (
    .src_addr        (rs2_addr_q),
    .reg_data        (rs2_data_q),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_data      (memwb_data_i),
    .data            (rs2_fwd),
    .fwd_sel         (rs2_sel)
  );

  // Select indicators are kept for debug visibility only.
  assign unused_fwd_sel = ^{rs1_sel, rs2_sel};

  // Operand steering: the immediate only replaces the ALU's second operand;
  // stores always see the forwarded rs2 value.
  always_comb begin
    alu_data1_o  = rs1_fwd;
    alu_data2_o  = alu_src_q ? imm_q : rs2_fwd;
    store_data_o = rs2_fwd;
  end

  assign alu_ctrl_o   = alu_ctrl_q;
  assign rd_addr_o    = rd_addr_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign valid_o      = valid_q;

  // Load in EX whose destination is read by the instruction now in ID.
  always_comb begin
    load_use_hazard_o = valid_i && valid_q && mem_read_q && (rd_addr_q != '0) &&
                        ((rd_addr_q == rs1_addr_i) || (rd_addr_q == rs2_addr_i));
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage.
module tb_id_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, valid_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [2:0]  alu_ctrl_i;
  logic        alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_data_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_data_i;
  logic [31:0] alu_data1_o, alu_data2_o, store_data_o;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o;
  logic        load_use_hazard_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
    .exmem_data_i(exmem_data_i), .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .valid_o(valid_o),
    .load_use_hazard_o(load_use_hazard_o)
  );

  // Advance one clock; inputs are changed and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i = 0; flush_i = 0; valid_i = 0;
    rs1_data_i = 0; rs2_data_i = 0; imm_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
    alu_ctrl_i = 0; alu_src_i = 0;
    reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0;
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rs1_data_i = 32'hDEAD; valid_i = 1; alu_ctrl_i = 3'd5; reg_write_i = 1;
    rst_i = 1;
    tick();
    tick();
    n_cmp++;
    if ({alu_data1_o, alu_data2_o, store_data_o} !== 96'h0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h expected 0", alu_data1_o, alu_data2_o, store_data_o);
    end
    n_cmp++;
    if ({alu_ctrl_o, rd_addr_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o} !== 13'h0) begin
      n_err++; $display("FAIL reset_ctrl: got ctrl=%0d rd=%0d rw=%b mr=%b mw=%b m2r=%b v=%b expected all 0",
                        alu_ctrl_o, rd_addr_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o);
    end
    @(negedge clk_i);
    rst_i = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_plain_capture();
    clear_inputs();
    valid_i = 1; alu_ctrl_i = 3'd3; rs1_data_i = 5; rs2_data_i = 7;
    rs1_addr_i = 1; rs2_addr_i = 2; rd_addr_i = 3; reg_write_i = 1;
    tick();
    n_cmp++;
    if (alu_data1_o !== 32'd5) begin n_err++; $display("FAIL cap_data1: got %h expected 5", alu_data1_o); end
    n_cmp++;
    if (alu_data2_o !== 32'd7) begin n_err++; $display("FAIL cap_data2: got %h expected 7", alu_data2_o); end
    n_cmp++;
    if (alu_ctrl_o !== 3'd3) begin n_err++; $display("FAIL cap_ctrl: got %0d expected 3", alu_ctrl_o); end
    n_cmp++;
    if ({valid_o, reg_write_o, rd_addr_o} !== {1'b1, 1'b1, 5'd3}) begin
      n_err++; $display("FAIL cap_ctl: got v=%b rw=%b rd=%0d expected 1 1 3", valid_o, reg_write_o, rd_addr_o);
    end
    n_cmp++;
    if (store_data_o !== 32'd7) begin n_err++; $display("FAIL cap_store: got %h expected 7", store_data_o); end
  endtask

  task automatic test_valid_gating();
    clear_inputs();
    valid_i = 0; reg_write_i = 1; mem_read_i = 1; mem_write_i = 1; rd_addr_i = 9;
    tick();
    n_cmp++;
    if ({valid_o, reg_write_o, mem_read_o, mem_write_o} !== 4'b0000) begin
      n_err++; $display("FAIL gate_ctl: got v=%b rw=%b mr=%b mw=%b expected 0 0 0 0",
                        valid_o, reg_write_o, mem_read_o, mem_write_o);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    valid_i = 1; alu_ctrl_i = 3'd3; rs1_addr_i = 3; rs1_data_i = 32'hAA;
    rs2_addr_i = 5; rs2_data_i = 32'hBB;
    tick();
    exmem_reg_write_i = 1; exmem_rd_i = 3; exmem_data_i = 32'h11;
    memwb_reg_write_i = 1; memwb_rd_i = 3; memwb_data_i = 32'h22;
    #1;
    n_cmp++;
    if (alu_data1_o !== 32'h11) begin n_err++; $display("FAIL prio_exmem: got %h expected 11", alu_data1_o); end
    exmem_reg_write_i = 0;
    #1;
    n_cmp++;
    if (alu_data1_o !== 32'h22) begin n_err++; $display("FAIL prio_memwb: got %h expected 22", alu_data1_o); end
    memwb_reg_write_i = 0;
    #1;
    n_cmp++;
    if (alu_data1_o !== 32'hAA) begin n_err++; $display("FAIL prio_none: got %h expected aa", alu_data1_o); end
    memwb_reg_write_i = 1; memwb_rd_i = 5; memwb_data_i = 32'h77;
    #1;
    n_cmp++;
    if ({alu_data1_o, alu_data2_o} !== {32'hAA, 32'h77}) begin
      n_err++; $display("FAIL prio_rs2: got %h %h expected aa 77", alu_data1_o, alu_data2_o);
    end
  endtask

  task automatic test_x0_imm();
    clear_inputs();
    valid_i = 1; alu_ctrl_i = 3'd6; alu_src_i = 1; imm_i = 32'hFFFF_FFFC;
    rs2_addr_i = 0; rs2_data_i = 32'h1234; rs1_addr_i = 0; rs1_data_i = 32'h4321;
    tick();
    exmem_reg_write_i = 1; exmem_rd_i = 0; exmem_data_i = 32'hFFFF;
    memwb_reg_write_i = 1; memwb_rd_i = 0; memwb_data_i = 32'hEEEE;
    #1;
    n_cmp++;
    if (alu_data2_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL x0_imm: got %h expected fffffffc", alu_data2_o); end
    n_cmp++;
    if (store_data_o !== 32'h1234) begin n_err++; $display("FAIL x0_store: got %h expected 1234", store_data_o); end
    n_cmp++;
    if (alu_data1_o !== 32'h4321) begin n_err++; $display("FAIL x0_rs1: got %h expected 4321", alu_data1_o); end
    n_cmp++;
    if (alu_ctrl_o !== 3'd6) begin n_err++; $display("FAIL x0_ctrl: got %0d expected 6", alu_ctrl_o); end
    clear_inputs();
    valid_i = 1; alu_src_i = 1; imm_i = 32'h10; rs2_addr_i = 6; rs2_data_i = 32'h1;
    tick();
    exmem_reg_write_i = 1; exmem_rd_i = 6; exmem_data_i = 32'h55;
    #1;
    n_cmp++;
    if ({alu_data2_o, store_data_o} !== {32'h10, 32'h55}) begin
      n_err++; $display("FAIL imm_store_fwd: got %h %h expected 10 55", alu_data2_o, store_data_o);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    valid_i = 1; alu_ctrl_i = 3'd3; mem_read_i = 1; reg_write_i = 1; mem_to_reg_i = 1;
    rd_addr_i = 4; rs1_addr_i = 1;
    tick();
    clear_inputs();
    valid_i = 1; rs1_addr_i = 4; rs2_addr_i = 2; rd_addr_i = 8; alu_ctrl_i = 3'd3; reg_write_i = 1;
    #1;
    n_cmp++;
    if (load_use_hazard_o !== 1'b1) begin n_err++; $display("FAIL lu_rs1: got %b expected 1", load_use_hazard_o); end
    rs1_addr_i = 1; rs2_addr_i = 4;
    #1;
    n_cmp++;
    if (load_use_hazard_o !== 1'b1) begin n_err++; $display("FAIL lu_rs2: got %b expected 1", load_use_hazard_o); end
    rs2_addr_i = 2;
    #1;
    n_cmp++;
    if (load_use_hazard_o !== 1'b0) begin n_err++; $display("FAIL lu_nomatch: got %b expected 0", load_use_hazard_o); end
    rs1_addr_i = 4; valid_i = 0;
    #1;
    n_cmp++;
    if (load_use_hazard_o !== 1'b0) begin n_err++; $display("FAIL lu_invalid: got %b expected 0", load_use_hazard_o); end
    valid_i = 1; flush_i = 1;
    tick();
    n_cmp++;
    if ({valid_o, reg_write_o, mem_read_o, load_use_hazard_o} !== 4'b0000) begin
      n_err++; $display("FAIL lu_flush: got v=%b rw=%b mr=%b hz=%b expected 0 0 0 0",
                        valid_o, reg_write_o, mem_read_o, load_use_hazard_o);
    end
    flush_i = 0; rs1_data_i = 32'h3;
    memwb_reg_write_i = 1; memwb_rd_i = 4; memwb_data_i = 32'h99;
    tick();
    n_cmp++;
    if ({valid_o, alu_data1_o} !== {1'b1, 32'h99}) begin
      n_err++; $display("FAIL lu_fwd: got v=%b d1=%h expected 1 99", valid_o, alu_data1_o);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    valid_i = 1; alu_ctrl_i = 3'd4; rs1_data_i = 32'h100; rs2_data_i = 32'h30;
    rs1_addr_i = 8; rs2_addr_i = 9; rd_addr_i = 7; reg_write_i = 1;
    tick();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      rs1_data_i = 32'h5000 + i; rs2_data_i = 32'h6000 + i; alu_ctrl_i = 3'd5;
      rd_addr_i = 5'd20 + 5'(i); valid_i = i[0]; reg_write_i = 0;
      tick();
      n_cmp++;
      if ({alu_data1_o, alu_data2_o, alu_ctrl_o, rd_addr_o, valid_o, reg_write_o} !==
          {32'h100, 32'h30, 3'd4, 5'd7, 1'b1, 1'b1}) begin
        n_err++; $display("FAIL stall_hold%0d: got d1=%h d2=%h ctrl=%0d rd=%0d v=%b rw=%b expected 100 30 4 7 1 1",
                          i, alu_data1_o, alu_data2_o, alu_ctrl_o, rd_addr_o, valid_o, reg_write_o);
      end
    end
    flush_i = 1;
    tick();
    n_cmp++;
    if ({valid_o, reg_write_o, alu_ctrl_o, alu_data1_o} !== {1'b0, 1'b0, 3'd0, 32'h0}) begin
      n_err++; $display("FAIL stall_flush: got v=%b rw=%b ctrl=%0d d1=%h expected 0 0 0 0",
                        valid_o, reg_write_o, alu_ctrl_o, alu_data1_o);
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    valid_i = 1; alu_ctrl_i = 3'd7; rs1_data_i = 32'hCAFE; rd_addr_i = 12; reg_write_i = 1;
    tick();
    n_cmp++;
    if ({valid_o, alu_data1_o} !== {1'b1, 32'hCAFE}) begin
      n_err++; $display("FAIL ar_pre: got v=%b d1=%h expected 1 cafe", valid_o, alu_data1_o);
    end
    #2;
    rst_i = 1;
    #1;
    n_cmp++;
    if ({valid_o, reg_write_o, alu_ctrl_o, alu_data1_o, rd_addr_o} !== {1'b0, 1'b0, 3'd0, 32'h0, 5'd0}) begin
      n_err++; $display("FAIL ar_async: got v=%b rw=%b ctrl=%0d d1=%h rd=%0d expected 0 0 0 0 0",
                        valid_o, reg_write_o, alu_ctrl_o, alu_data1_o, rd_addr_o);
    end
    @(negedge clk_i);
    rst_i = 0;
    clear_inputs();
    tick();
    n_cmp++;
    if ({valid_o, reg_write_o} !== 2'b00) begin
      n_err++; $display("FAIL ar_bubble: got v=%b rw=%b expected 0 0", valid_o, reg_write_o);
    end
  endtask

  initial begin
    rst_i = 1;
    clear_inputs();
    test_reset();
    test_plain_capture();
    test_valid_gating();
    test_priority();
    test_x0_imm();
    test_load_use();
    test_stall_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding for the 5-stage RISC-V core.
- Captures decoded operands and control from ID on each clock.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then drives the ALU's data1_i, data2_i and ALUCtrl_i directly.
- Flags load-use hazards back to the hazard/stall logic.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- stall_i  in  1  hold all stage registers
- flush_i  in  1  replace captured instruction with bubble
- valid_i  in  1  ID holds a real instruction
- rs1_data_i  in  XLEN  register-file read data 1
- rs2_data_i  in  XLEN  register-file read data 2
- imm_i  in  XLEN  sign-extended immediate
- rs1_addr_i  in  RADDR_W  source 1 index
- rs2_addr_i  in  RADDR_W  source 2 index
- rd_addr_i  in  RADDR_W  destination index
- alu_ctrl_i  in  3  ALU op code (AND=0, XOR=1, SLL=2, ADD=3, SUB=4, MUL=5, ADDI=6, SRAI=7)
- alu_src_i  in  1  1 = immediate as operand 2
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1 each  control bits
- exmem_reg_write_i  in  1  EX/MEM writes a register
- exmem_rd_i  in  RADDR_W  EX/MEM destination
- exmem_data_i  in  XLEN  EX/MEM ALU result
- memwb_reg_write_i  in  1  MEM/WB writes a register
- memwb_rd_i  in  RADDR_W  MEM/WB destination
- memwb_data_i  in  XLEN  MEM/WB write-back value
- alu_data1_o  out  XLEN  to ALU data1_i
- alu_data2_o  out  XLEN  to ALU data2_i
- alu_ctrl_o  out  3  to ALU ALUCtrl_i
- store_data_o  out  XLEN  forwarded rs2, for stores
- rd_addr_o  out  RADDR_W  registered destination
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each  registered control
- valid_o  out  1  stage holds a real instruction
- load_use_hazard_o  out  1  ID must stall one cycle

Behaviour:
- Registers: valid, rs1/rs2 data, imm, rs1/rs2/rd addr, alu_ctrl, alu_src, 4 control bits.
- Reset (async, rst_i=1): every register is 0. All registered outputs are 0. alu_ctrl_o=0 (AND), valid_o=0.
- Clock edge priority: flush_i > stall_i > load.
- flush_i=1: valid and all control bits (reg_write, mem_read, mem_write, mem_to_reg) clear to 0. alu_ctrl clears to 0. Data fields are don't-care and are cleared to 0.
- stall_i=1 (no flush): all registers hold.
- Otherwise: capture all *_i inputs.
- Control bits are gated by valid. A captured valid_i=0 forces reg_write_o=mem_write_o=mem_read_o=0.
- Latency: 1 cycle from ID inputs to registered outputs.
- Forwarding is combinational on registered values, evaluated per source (src = rs1 or rs2):
  - If exmem_reg_write_i && exmem_rd_i!=0 && exmem_rd_i==src, use exmem_data_i.
  - Else if memwb_reg_write_i && memwb_rd_i!=0 && memwb_rd_i==src, use memwb_data_i.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB when both match. x0 is never forwarded.
- Operand outputs:
  - alu_data1_o = forwarded rs1.
  - alu_data2_o = imm when alu_src=1, else forwarded rs2.
  - store_data_o = forwarded rs2, regardless of alu_src.
- Shift width: the stage passes the full XLEN value; the ALU uses [4:0].
- load_use_hazard_o = valid_o && mem_read_o && rd_addr_o!=0 && (rd_addr_o==rs1_addr_i || rd_addr_o==rs2_addr_i). This is combinational and is qualified by valid_i.
- Load-use flow: the external hazard unit stalls IF/ID and asserts flush_i to this stage for exactly that cycle. The next cycle's MEM/WB forward then supplies the load data.
- Reset mid-stream: outputs drop to 0 immediately (async), and the pipeline restarts from a bubble.

Decomposition:
- Shared package holds:
  - ALU op constants: AND, XOR, SLL, ADD, SUB, MUL, ADDI, SRAI, same 3-bit codes as the ALU.
  - XLEN and RADDR_W.
  - fwd_sel encoding: NONE=0, EXMEM=1, MEMWB=2.
- One sub-module: fwd_mux, instantiated twice (rs1, rs2). Inputs: src addr, reg data, both bypass triplets. Outputs: selected data and fwd_sel.

Test Plan:
- Reset then plain capture: rst_i pulse, then ID ADD, rs1=5, rs2=7, no bypass writes. Next cycle alu_data1_o=5, alu_data2_o=7, alu_ctrl_o=3, valid_o=1. During reset all outputs are 0.
- Double-hit priority: registered rs1_addr=3; exmem rd=3 data=0x11 and memwb rd=3 data=0x22, both writing. Expect alu_data1_o=0x11. Deassert exmem_reg_write_i, expect 0x22.
- x0 guard and immediate: rs2_addr=0, exmem rd=0 data=0xFFFF, alu_src=1, imm=0xFFFFFFFC (ADDI). Expect alu_data2_o=0xFFFFFFFC and store_data_o=original rs2 data.
- Load-use: stage holds lw with rd=4; ID presents rs1_addr=4 with valid_i=1. Expect load_use_hazard_o=1. Then apply flush_i, expect valid_o=0 and reg_write_o=0. Next cycle with memwb rd=4 data=0x99 forwarding, alu_data1_o=0x99.
- Stall vs flush: capture SUB, then stall_i=1 for 3 cycles with changing inputs. Outputs must stay constant. Then stall_i=1 with flush_i=1 gives a bubble (valid_o=0).
- Async reset mid-operation: assert rst_i between clock edges while valid_o=1. Outputs go to 0 before the next edge.
